// File: rtl/sc_level_scheduler.sv
// rtl/sc_level_scheduler.sv - level/transition scheduler driving road LOAD pulses, level and mux selects
module sc_level_scheduler #(
    parameter int PERIOD_L1 = 17500000,
    parameter int PERIOD_L2 = 15000000,
    parameter int PERIOD_L3 = 12500000,
    parameter int LV1_END   = 10,
    parameter int TR1_END   = 17,
    parameter int LV2_END   = 32,
    parameter int TR2_END   = 39,
    parameter int LV3_END   = 59
) (
    input  logic       SC_LEVEL_SCHEDULER_CLOCK_50,
    input  logic       SC_LEVEL_SCHEDULER_RESET_InHigh,
    input  logic       SC_LEVEL_SCHEDULER_START_InLow,
    input  logic       SC_LEVEL_SCHEDULER_COMPARATOR,
    output logic       SC_LEVEL_SCHEDULER_LOAD_Out,
    output logic [1:0] SC_LEVEL_SCHEDULER_LEVEL_Out,
    output logic       SC_LEVEL_SCHEDULER_MUX_SEL_1_Out,
    output logic       SC_LEVEL_SCHEDULER_MUX_SEL_2_Out,
    output logic       SC_LEVEL_SCHEDULER_MUX_SEL_3_Out,
    output logic [7:0] SC_LEVEL_SCHEDULER_PROGRESS_Out,
    output logic       SC_LEVEL_SCHEDULER_HALT_Out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEVEL1 = 3'd1,
        S_TRANS1 = 3'd2,
        S_LEVEL2 = 3'd3,
        S_TRANS2 = 3'd4,
        S_LEVEL3 = 3'd5,
        S_DONE   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [24:0] P1_LAST = 25'(PERIOD_L1 - 1);
    localparam logic [24:0] P2_LAST = 25'(PERIOD_L2 - 1);
    localparam logic [24:0] P3_LAST = 25'(PERIOD_L3 - 1);
    localparam logic [7:0]  LV1_TH  = 8'(LV1_END);
    localparam logic [7:0]  TR1_TH  = 8'(TR1_END);
    localparam logic [7:0]  LV2_TH  = 8'(LV2_END);
    localparam logic [7:0]  TR2_TH  = 8'(TR2_END);
    localparam logic [7:0]  LV3_TH  = 8'(LV3_END);

    state_t      state_q, state_d;
    logic [24:0] presc_q, presc_d;
    logic [7:0]  progress_q, progress_d;
    logic        load_q, load_d;
    logic        start_prev_q;
    logic [1:0]  level_q, level_d;
    logic        mux1_q, mux1_d;
    logic        mux2_q, mux2_d;
    logic        mux3_q, mux3_d;
    logic        halt_q, halt_d;

    logic        clk;
    logic        start_ev;
    logic        in_play;
    logic        terminal;
    logic        collide;
    logic [24:0] period_last;
    logic [7:0]  prog_inc;

    assign clk = SC_LEVEL_SCHEDULER_CLOCK_50;

    // Start is the falling edge of the active-low button; holding it yields a single event.
    assign start_ev = ~SC_LEVEL_SCHEDULER_START_InLow & start_prev_q;
    assign in_play  = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_HALT);
    assign collide  = in_play & SC_LEVEL_SCHEDULER_COMPARATOR;
    assign prog_inc = progress_q + 8'd1;

    // Select the prescaler period for the current play state.
    always_comb begin
        period_last = P3_LAST;
        case (state_q)
            S_LEVEL1, S_TRANS1: period_last = P1_LAST;
            S_LEVEL2, S_TRANS2: period_last = P2_LAST;
            default:            period_last = P3_LAST;
        endcase
    end

    assign terminal = in_play && (presc_q == period_last);

    // State register plus all registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (SC_LEVEL_SCHEDULER_RESET_InHigh) begin
            state_q      <= S_IDLE;
            presc_q      <= 25'd0;
            progress_q   <= 8'd0;
            load_q       <= 1'b0;
            start_prev_q <= 1'b1;
            level_q      <= 2'd0;
            mux1_q       <= 1'b0;
            mux2_q       <= 1'b0;
            mux3_q       <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            progress_q   <= progress_d;
            load_q       <= load_d;
            start_prev_q <= SC_LEVEL_SCHEDULER_START_InLow;
            level_q      <= level_d;
            mux1_q       <= mux1_d;
            mux2_q       <= mux2_d;
            mux3_q       <= mux3_d;
            halt_q       <= halt_d;
        end
    end

    // Next state: collision beats a terminal count; thresholds are checked against the incremented progress.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_ev) state_d = S_LEVEL1;
            S_LEVEL1: if (collide) state_d = S_HALT;
                      else if (terminal && prog_inc == LV1_TH) state_d = S_TRANS1;
            S_TRANS1: if (collide) state_d = S_HALT;
                      else if (terminal && prog_inc == TR1_TH) state_d = S_LEVEL2;
            S_LEVEL2: if (collide) state_d = S_HALT;
                      else if (terminal && prog_inc == LV2_TH) state_d = S_TRANS2;
            S_TRANS2: if (collide) state_d = S_HALT;
                      else if (terminal && prog_inc == TR2_TH) state_d = S_LEVEL3;
            S_LEVEL3: if (collide) state_d = S_HALT;
                      else if (terminal && prog_inc == LV3_TH) state_d = S_DONE;
            S_DONE:   if (start_ev) state_d = S_IDLE;
            S_HALT:   if (start_ev) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values, decoded from the state being entered so outputs stay registered.
    always_comb begin
        load_d     = terminal & ~collide;
        progress_d = progress_q;
        presc_d    = 25'd0;
        if (state_d == S_IDLE) begin
            progress_d = 8'd0;
        end else if (load_d) begin
            progress_d = prog_inc;
        end
        if (in_play && (state_d == state_q) && !terminal) begin
            presc_d = presc_q + 25'd1;
        end
        level_d = 2'd0;
        case (state_d)
            S_LEVEL1, S_TRANS1: level_d = 2'd1;
            S_LEVEL2, S_TRANS2: level_d = 2'd2;
            S_LEVEL3:           level_d = 2'd3;
            default:            level_d = 2'd0;
        endcase
        mux1_d = (state_d == S_TRANS1);
        mux2_d = (state_d == S_TRANS2);
        mux3_d = (state_d == S_DONE);
        halt_d = (state_d == S_HALT);
    end

    assign SC_LEVEL_SCHEDULER_LOAD_Out       = load_q;
    assign SC_LEVEL_SCHEDULER_LEVEL_Out      = level_q;
    assign SC_LEVEL_SCHEDULER_MUX_SEL_1_Out  = mux1_q;
    assign SC_LEVEL_SCHEDULER_MUX_SEL_2_Out  = mux2_q;
    assign SC_LEVEL_SCHEDULER_MUX_SEL_3_Out  = mux3_q;
    assign SC_LEVEL_SCHEDULER_PROGRESS_Out   = progress_q;
    assign SC_LEVEL_SCHEDULER_HALT_Out       = halt_q;

endmodule
